// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, dual write ports and clear handshake.
// master drives addresses/writes/clear requests, slave is the register file.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_adr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [1:0]               wr_en;
    logic [2*ADDR_W-1:0]      wr_adr;
    logic [2*DATA_W-1:0]      wr_data;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     wr_conflict;

    modport master (
        output rd_adr, wr_en, wr_adr, wr_data, clr_req,
        input  rd_data, clr_busy, wr_conflict
    );

    modport slave (
        input  rd_adr, wr_en, wr_adr, wr_data, clr_req,
        output rd_data, clr_busy, wr_conflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with dual write (port 1 wins), sequenced bulk clear and r0 == 0.
// Optional same-cycle write-to-read forwarding under REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_mp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = '1;

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                wr_conflict_q, wr_conflict_d;
    logic                clr_busy;

    logic [ADDR_W-1:0]   wa [2];
    logic [DATA_W-1:0]   wd [2];
    logic [ADDR_W-1:0]   ra [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data;

    assign clr_busy = (state_q == StClear);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wa[k] = bus.wr_adr[k*ADDR_W +: ADDR_W];
            wd[k] = bus.wr_data[k*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_RD; i++) begin
            ra[i] = bus.rd_adr[i*ADDR_W +: ADDR_W];
        end
    end

    // Clear sweep: idx walks 1..DEPTH-1, one entry per edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    idx_d   = ADDR_W'(1);
                end
            end
            StClear: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_busy) begin
            mem_d[idx_q] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (bus.wr_en[k] && (wa[k] != '0)) begin
                    mem_d[wa[k]] = wd[k];
                end
            end
        end
        mem_d[0] = '0;
    end

    assign wr_conflict_d = !clr_busy && (bus.wr_en == 2'b11) &&
                           (wa[0] == wa[1]) && (wa[0] != '0);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = (ra[i] == '0) ? '0 : mem_q[ra[i]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (!clr_busy && (ra[i] != '0)) begin
                if (bus.wr_en[1] && (wa[1] == ra[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = wd[1];
                end else if (bus.wr_en[0] && (wa[0] == ra[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = wd[0];
                end
            end
`endif
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.clr_busy    = clr_busy;
    assign bus.wr_conflict = wr_conflict_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            wr_conflict_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_conflict_q <= wr_conflict_d;
            mem_q         <= mem_d;
        end
    end
endmodule
